// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register for the MIPS CPU.
// It carries {valid, instruction, payload} through DEPTH stages. It supports
// stall, flush and synchronous reset, counts retired instructions, and can
// halt the pipeline when a valid BREAK reaches the last stage.
//
// Handshake: there is no valid/ready pair. ValidIn qualifies the upstream
// slot, and StallIn works as an inverted "ready" from downstream: when it is
// low and the block is running, every stage moves forward by one. FlushIn
// takes priority over StallIn. In the HALTED state both inputs are ignored.
module pipe_stage_reg #(
  parameter int DATA_W       = 180,
  parameter int DEPTH        = 1,
  parameter int BREAK_DETECT = 1,
  parameter int CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              StallIn,
  input  logic              FlushIn,
  input  logic              ValidIn,
  input  logic [31:0]       InstructIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ValidOut,
  output logic [31:0]       InstructOut,
  output logic [DATA_W-1:0] DataOut,
  output logic              BreakOut,
  output logic              HaltOut,
  output logic [CNT_W-1:0]  RetireCount
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // state is left as a named signal so checkers can bind to it directly
  state_t state;
  state_t state_next;

  logic [DEPTH-1:0]  valid_q;
  logic [31:0]       instr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [CNT_W-1:0]  count_q;
  logic              break_q;

  logic              running;
  logic              advance;
  logic              flush;

  // stage-0 input: an invalid slot always enters as a NOP with zero payload
  logic              in_valid;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_data;

  // the value the last stage loads on an advancing edge
  logic              load_valid;
  logic [31:0]       load_instr;
  logic              is_break;

  assign running  = (state == RUN);
  assign advance  = running && !StallIn && !FlushIn;
  assign flush    = running && FlushIn;

  assign in_valid = ValidIn;
  assign in_instr = ValidIn ? InstructIn : 32'd0;
  assign in_data  = ValidIn ? DataIn : '0;

  generate
    if (DEPTH == 1) begin : g_load_single
      assign load_valid = in_valid;
      assign load_instr = in_instr;
    end else begin : g_load_chain
      assign load_valid = valid_q[DEPTH-2];
      assign load_instr = instr_q[DEPTH-2];
    end
  endgenerate

  // Only the word captured into the last stage can trigger a halt
  generate
    if (BREAK_DETECT != 0) begin : g_break_on
      assign is_break = advance && load_valid &&
                        (load_instr[31:26] == 6'h00) &&
                        (load_instr[5:0]   == 6'h0D);
    end else begin : g_break_off
      assign is_break = 1'b0;
    end
  endgenerate

  // Stage registers: reset and flush both bubble every stage; otherwise shift on advance
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= 32'd0;
        data_q[i]  <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      instr_q[0] <= in_instr;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        instr_q[i] <= instr_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Halt FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Halt FSM next state: HALTED can only be left through reset
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (is_break) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // One-cycle BREAK pulse, aligned with the BREAK appearing at the output
  always_ff @(posedge CLK) begin
    if (RST) begin
      break_q <= 1'b0;
    end else begin
      break_q <= is_break;
    end
  end

  // Retire counter: counts the valid word leaving the last stage on an advancing edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (advance && valid_q[DEPTH-1]) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign ValidOut    = valid_q[DEPTH-1];
  assign InstructOut = instr_q[DEPTH-1];
  assign DataOut     = data_q[DEPTH-1];
  assign BreakOut    = break_q;
  assign HaltOut     = (state == HALTED);
  assign RetireCount = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. Four instances share
// the same stimulus: default (DEPTH=1), DEPTH=3, BREAK_DETECT=0, and CNT_W=4.
module tb_pipe_stage_reg;

  localparam int DW = 180;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          vin;
  logic [31:0]   iin;
  logic [DW-1:0] din;

  logic          a_valid, a_brk, a_halt;
  logic [31:0]   a_instr;
  logic [DW-1:0] a_data;
  logic [31:0]   a_cnt;

  logic          b_valid, b_brk, b_halt;
  logic [31:0]   b_instr;
  logic [DW-1:0] b_data;
  logic [31:0]   b_cnt;

  logic          c_valid, c_brk, c_halt;
  logic [31:0]   c_instr;
  logic [DW-1:0] c_data;
  logic [31:0]   c_cnt;

  logic          w_valid, w_brk, w_halt;
  logic [31:0]   w_instr;
  logic [DW-1:0] w_data;
  logic [3:0]    w_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .BREAK_DETECT(1), .CNT_W(32)) dut_a (
    .CLK(clk), .RST(rst), .StallIn(stall), .FlushIn(flush), .ValidIn(vin),
    .InstructIn(iin), .DataIn(din), .ValidOut(a_valid), .InstructOut(a_instr),
    .DataOut(a_data), .BreakOut(a_brk), .HaltOut(a_halt), .RetireCount(a_cnt));

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(3), .BREAK_DETECT(1), .CNT_W(32)) dut_b (
    .CLK(clk), .RST(rst), .StallIn(stall), .FlushIn(flush), .ValidIn(vin),
    .InstructIn(iin), .DataIn(din), .ValidOut(b_valid), .InstructOut(b_instr),
    .DataOut(b_data), .BreakOut(b_brk), .HaltOut(b_halt), .RetireCount(b_cnt));

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .BREAK_DETECT(0), .CNT_W(32)) dut_c (
    .CLK(clk), .RST(rst), .StallIn(stall), .FlushIn(flush), .ValidIn(vin),
    .InstructIn(iin), .DataIn(din), .ValidOut(c_valid), .InstructOut(c_instr),
    .DataOut(c_data), .BreakOut(c_brk), .HaltOut(c_halt), .RetireCount(c_cnt));

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .BREAK_DETECT(1), .CNT_W(4)) dut_w (
    .CLK(clk), .RST(rst), .StallIn(stall), .FlushIn(flush), .ValidIn(vin),
    .InstructIn(iin), .DataIn(din), .ValidOut(w_valid), .InstructOut(w_instr),
    .DataOut(w_data), .BreakOut(w_brk), .HaltOut(w_halt), .RetireCount(w_cnt));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [DW-1:0] d,
                       input logic s, input logic f);
    vin = v; iin = i; din = d; stall = s; flush = f;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a_valid, a_instr, a_data, a_brk, a_halt, a_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got valid=%b instr=%h halt=%b brk=%b cnt=%0d, want all 0",
               a_valid, a_instr, a_halt, a_brk, a_cnt);
    end
    n_checks++;
    if ({b_valid, b_instr, b_data, b_brk, b_halt, b_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got valid=%b instr=%h halt=%b cnt=%0d, want all 0",
               b_valid, b_instr, b_halt, b_cnt);
    end
  endtask

  task automatic test_advance();
    do_reset();
    drive(1'b1, 32'h012A4020, DW'(5), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_instr !== 32'h012A4020 || a_data !== DW'(5)) begin
      n_fail++;
      $display("FAIL advance_out: got valid=%b instr=%h data=%0d, want 1 012a4020 5",
               a_valid, a_instr, a_data);
    end
    drive(1'b0, 32'h012A4020, DW'(9), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_cnt !== 32'd1 || a_valid !== 1'b0 || a_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL advance_retire: got cnt=%0d valid=%b instr=%h, want 1 0 0",
               a_cnt, a_valid, a_instr);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1'b1, 32'h01095022, DW'(7), 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h02000000 + k, DW'(100 + k), 1'b1, 1'b0);
      step();
      n_checks++;
      if (a_valid !== 1'b1 || a_instr !== 32'h01095022 || a_data !== DW'(7) || a_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b instr=%h data=%0d cnt=%0d, want 1 01095022 7 0",
                 k, a_valid, a_instr, a_data, a_cnt);
      end
    end
    drive(1'b1, 32'h03000000, DW'(55), 1'b1, 1'b1);
    step();
    n_checks++;
    if (a_valid !== 1'b0 || a_instr !== 32'd0 || a_data !== '0 || a_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got valid=%b instr=%h data=%0d cnt=%0d, want 0 0 0 0",
               a_valid, a_instr, a_data, a_cnt);
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_instr [5];
    logic        exp_valid [5];
    exp_instr[0] = 32'd0; exp_valid[0] = 1'b0;
    exp_instr[1] = 32'd0; exp_valid[1] = 1'b0;
    exp_instr[2] = 32'd1; exp_valid[2] = 1'b1;
    exp_instr[3] = 32'd2; exp_valid[3] = 1'b1;
    exp_instr[4] = 32'd3; exp_valid[4] = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, 32'(k + 1), DW'(k + 1), 1'b0, 1'b0);
      else       drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
      step();
      n_checks++;
      if (b_valid !== exp_valid[k] || b_instr !== exp_instr[k]) begin
        n_fail++;
        $display("FAIL latency_edge%0d: got valid=%b instr=%h, want %b %h",
                 k + 1, b_valid, b_instr, exp_valid[k], exp_instr[k]);
      end
    end
    n_checks++;
    if (b_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL latency_count: got %0d, want 2", b_cnt);
    end
  endtask

  task automatic test_flush_in_flight();
    do_reset();
    drive(1'b1, 32'd1, DW'(1), 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd2, DW'(2), 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd3, DW'(3), 1'b0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (b_valid !== 1'b0 || b_instr !== 32'd0) begin
        n_fail++;
        $display("FAIL flush_flight[%0d]: got valid=%b instr=%h, want 0 0", k, b_valid, b_instr);
      end
      drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
      if (k < 2) step();
    end
    n_checks++;
    if (b_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL flush_flight_count: got %0d, want 0", b_cnt);
    end
  endtask

  task automatic test_break_halt();
    do_reset();
    drive(1'b1, 32'h0000000D, DW'(3), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_halt !== 1'b1 || a_brk !== 1'b1 || a_valid !== 1'b1 || a_instr !== 32'h0000000D || a_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL break_capture: got halt=%b brk=%b valid=%b instr=%h cnt=%0d, want 1 1 1 0000000d 0",
               a_halt, a_brk, a_valid, a_instr, a_cnt);
    end
    n_checks++;
    if (c_halt !== 1'b0 || c_brk !== 1'b0 || c_valid !== 1'b1 || c_instr !== 32'h0000000D) begin
      n_fail++;
      $display("FAIL break_disabled: got halt=%b brk=%b valid=%b instr=%h, want 0 0 1 0000000d",
               c_halt, c_brk, c_valid, c_instr);
    end
    drive(1'b1, 32'h012A4020, DW'(8), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_halt !== 1'b1 || a_brk !== 1'b0 || a_instr !== 32'h0000000D || a_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL break_hold: got halt=%b brk=%b instr=%h cnt=%0d, want 1 0 0000000d 0",
               a_halt, a_brk, a_instr, a_cnt);
    end
    n_checks++;
    if (c_instr !== 32'h012A4020 || c_cnt !== 32'd1 || c_halt !== 1'b0) begin
      n_fail++;
      $display("FAIL break_disabled_pass: got instr=%h cnt=%0d halt=%b, want 012a4020 1 0",
               c_instr, c_cnt, c_halt);
    end
    drive(1'b1, 32'h01095022, DW'(4), 1'b1, 1'b1);
    step();
    n_checks++;
    if (a_halt !== 1'b1 || a_valid !== 1'b1 || a_instr !== 32'h0000000D || a_data !== DW'(3)) begin
      n_fail++;
      $display("FAIL break_ignore_flush: got halt=%b valid=%b instr=%h data=%0d, want 1 1 0000000d 3",
               a_halt, a_valid, a_instr, a_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (a_halt !== 1'b0 || a_cnt !== 32'd0 || a_valid !== 1'b0 || a_brk !== 1'b0) begin
      n_fail++;
      $display("FAIL break_reset: got halt=%b cnt=%0d valid=%b brk=%b, want 0 0 0 0",
               a_halt, a_cnt, a_valid, a_brk);
    end
    // the block must be running again after reset
    drive(1'b1, 32'h012A4020, DW'(1), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_valid !== 1'b1 || a_instr !== 32'h012A4020) begin
      n_fail++;
      $display("FAIL break_rerun: got valid=%b instr=%h, want 1 012a4020", a_valid, a_instr);
    end
  endtask

  task automatic test_bubbled_break();
    do_reset();
    drive(1'b0, 32'h0000000D, DW'(6), 1'b0, 1'b0);
    step();
    n_checks++;
    if (a_halt !== 1'b0 || a_brk !== 1'b0 || a_instr !== 32'd0 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bubbled_break: got halt=%b brk=%b instr=%h valid=%b, want 0 0 0 0",
               a_halt, a_brk, a_instr, a_valid);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, 32'h20000000 + k, DW'(k), 1'b0, 1'b0);
      step();
    end
    n_checks++;
    if (w_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_16: got %0d, want 0", w_cnt);
    end
    drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (w_cnt !== 4'd1 || a_cnt !== 32'd17) begin
      n_fail++;
      $display("FAIL wrap_17: got w=%0d a=%0d, want 1 17", w_cnt, a_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, '0, 1'b0, 1'b0);
    test_reset();
    test_advance();
    test_stall_flush();
    test_latency();
    test_flush_in_flight();
    test_break_halt();
    test_bubbled_break();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
